tick_scheduler: RTL and testbench

// - Game-tick controller for the snake datapath: replaces the externally toggled phase input with internal pacing.
// - Counts VGA frames and issues one o_tick pulse per period; the snake engine advances one step per pulse.
// - Holds ticks off while the apple search is not ready or a snake segment scan is in progress.
// - Speeds up as apples are eaten; handles the start, pause, game-over and win states.

---
 rtl/tick_scheduler_if.sv | 45 ++++
 rtl/tick_scheduler.sv | 138 +++++++++++++
 tb/tb_tick_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: control/status bundle between the game logic and the
// tick scheduler.
//   master : game-side driver (drives i_* stimulus, observes o_* status)
//   slave  : tick_scheduler (consumes i_*, produces o_*)
// Signals:
//   i_frame   1-cycle pulse per video frame
//   i_start   level, starts the game from IDLE
//   i_pause   button level, each rising edge toggles RUN/PAUSE
//   i_boost   level, fast mode (only honoured with SCHED_BOOST_EN)
//   i_ready   apple logic can accept a tick
//   i_busy    snake segment scan in progress
//   i_eat     1-cycle pulse, apple eaten
//   i_failure 1-cycle pulse, collision
//   i_success 1-cycle pulse, board full
//   o_tick    1-cycle game-tick pulse
//   o_state   IDLE=0 RUN=1 PAUSE=2 OVER=3 WIN=4
//   o_level   current speed level
//   o_missed  saturating count of overrun periods
interface tick_scheduler_if;
  logic       i_frame;
  logic       i_start;
  logic       i_pause;
  logic       i_boost;
  logic       i_ready;
  logic       i_busy;
  logic       i_eat;
  logic       i_failure;
  logic       i_success;
  logic       o_tick;
  logic [2:0] o_state;
  logic [3:0] o_level;
  logic [3:0] o_missed;

  modport master (
    output i_frame, i_start, i_pause, i_boost, i_ready, i_busy,
           i_eat, i_failure, i_success,
    input  o_tick, o_state, o_level, o_missed
  );

  modport slave (
    input  i_frame, i_start, i_pause, i_boost, i_ready, i_busy,
           i_eat, i_failure, i_success,
    output o_tick, o_state, o_level, o_missed
  );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: game-tick pacing for the snake datapath.
// Counts video frames and emits one o_tick per period, holding the tick
// back while the apple logic is not ready or a segment scan is running.
// The period shrinks as apples are eaten (level), and the block tracks
// the IDLE/RUN/PAUSE/OVER/WIN game state.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  tick_scheduler_if.slave (frame/start/pause/boost/ready/busy/eat/
//        failure/success in; tick/state/level/missed out)
// Optional feature: define SCHED_BOOST_EN to halve the period while
// i_boost=1 (floored at 1). Without it i_boost is ignored.
module tick_scheduler #(
  parameter int BASE_PERIOD      = 30,
  parameter int MIN_PERIOD       = 6,
  parameter int STEP             = 2,
  parameter int APPLES_PER_LEVEL = 4,
  parameter int MAX_LEVEL        = 12
) (
  input  logic              clk,
  input  logic              rst,
  tick_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t     r_state, w_next;
  logic       r_pause_q;
  logic       r_tick;
  logic       r_pending;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_eat_cnt;
  logic [3:0] r_level;
  logic [3:0] r_missed;

  // ---------------- period ----------------
  logic [7:0] w_dec, w_sub, w_period, w_period_eff;

  assign w_dec    = 8'(r_level) * 8'(STEP);
  // Clamp the subtraction at 0 before applying the floor so a large
  // level can never wrap around to a huge period.
  assign w_sub    = (w_dec >= 8'(BASE_PERIOD)) ? 8'd0 : 8'(BASE_PERIOD) - w_dec;
  assign w_period = (w_sub < 8'(MIN_PERIOD)) ? 8'(MIN_PERIOD) : w_sub;

`ifdef SCHED_BOOST_EN
  logic [7:0] w_half;
  assign w_half       = w_period >> 1;
  assign w_period_eff = bus.i_boost ? ((w_half == 8'd0) ? 8'd1 : w_half) : w_period;
`else
  logic w_unused_boost;
  assign w_unused_boost = bus.i_boost;
  assign w_period_eff   = w_period;
`endif

  // ---------------- FSM next state ----------------
  logic w_pedge;
  assign w_pedge = bus.i_pause & ~r_pause_q;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_RUN;
      S_RUN: begin
        if      (bus.i_failure) w_next = S_OVER;
        else if (bus.i_success) w_next = S_WIN;
        else if (w_pedge)       w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if      (bus.i_failure) w_next = S_OVER;
        else if (bus.i_success) w_next = S_WIN;
        else if (w_pedge)       w_next = S_RUN;
      end
      S_OVER:  w_next = S_OVER;
      S_WIN:   w_next = S_WIN;
      default: w_next = S_IDLE;
    endcase
  end

  // Pacing only runs while we are in RUN and stay there this cycle; a
  // cycle that leaves RUN neither counts, fires, nor keeps a pending tick.
  logic w_run, w_expire, w_fire;
  assign w_run    = (r_state == S_RUN) && (w_next == S_RUN);
  assign w_expire = w_run && bus.i_frame && ((r_frame_cnt + 8'd1) >= w_period_eff);
  assign w_fire   = w_run && r_pending && bus.i_ready && !bus.i_busy;

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pause_q   <= bus.i_pause;
      r_tick      <= 1'b0;
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_eat_cnt   <= 8'd0;
      r_level     <= 4'd0;
      r_missed    <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_pause_q <= bus.i_pause;
      r_tick    <= w_fire;

      if (r_state == S_IDLE)
        r_frame_cnt <= 8'd0;
      else if (w_run && bus.i_frame)
        r_frame_cnt <= w_expire ? 8'd0 : r_frame_cnt + 8'd1;

      // Expiry wins over a same-cycle fire: the fired tick goes out and
      // the new period's tick is already pending.
      if (!w_run)        r_pending <= 1'b0;
      else if (w_expire) r_pending <= 1'b1;
      else if (w_fire)   r_pending <= 1'b0;

      if (w_expire && r_pending && (r_missed != 4'hF))
        r_missed <= r_missed + 4'd1;

      if ((r_state == S_RUN) && bus.i_eat) begin
        if (r_eat_cnt == 8'(APPLES_PER_LEVEL - 1)) begin
          r_eat_cnt <= 8'd0;
          if (r_level < 4'(MAX_LEVEL)) r_level <= r_level + 4'd1;
        end else begin
          r_eat_cnt <= r_eat_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.o_tick   = r_tick;
  assign bus.o_state  = r_state;
  assign bus.o_level  = r_level;
  assign bus.o_missed = r_missed;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: reset, basic pacing, busy/ready
// hold-off, overrun counting, level speed-up, pause, terminal states and
// the optional boost mode.
module tb_tick_scheduler;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;
  int   c0;

  tick_scheduler_if sif ();

  tick_scheduler dut (.clk(clk), .rst(rst), .bus(sif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every cycle in which o_tick was high.
  always @(posedge clk) if (sif.o_tick) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      sif.i_frame = 1'b1; @(negedge clk);
      sif.i_frame = 1'b0; @(negedge clk);
    end
  endtask

  task automatic eats(input int n);
    repeat (n) begin
      sif.i_eat = 1'b1; @(negedge clk);
      sif.i_eat = 1'b0; @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  task automatic start();
    sif.i_start = 1'b1; step(1); sif.i_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sif.i_frame = 0; sif.i_start = 0; sif.i_pause = 0; sif.i_boost = 0;
    sif.i_ready = 1; sif.i_busy = 0; sif.i_eat = 0;
    sif.i_failure = 0; sif.i_success = 0;
    step(2);
    check("rst_state",  int'(sif.o_state),  0);
    check("rst_tick",   int'(sif.o_tick),   0);
    check("rst_level",  int'(sif.o_level),  0);
    check("rst_missed", int'(sif.o_missed), 0);
    rst = 1'b0;

    // basic pacing: tick one cycle after the 30th frame
    start();
    check("start_state", int'(sif.o_state), 1);
    frames(29);
    check("no_tick_29", tick_cnt, 0);
    frames(1);
    check("tick_30", int'(sif.o_tick), 1);
    step(1);
    check("tick_1cyc", int'(sif.o_tick), 0);
    check("tick_count1", tick_cnt, 1);
    check("run_state", int'(sif.o_state), 1);

    // busy holds the tick until it falls
    sif.i_busy = 1'b1;
    frames(30);
    step(5);
    check("busy_hold", int'(sif.o_tick), 0);
    check("busy_cnt", tick_cnt, 1);
    sif.i_busy = 1'b0;
    step(1);
    check("busy_release_tick", int'(sif.o_tick), 1);
    check("busy_missed", int'(sif.o_missed), 0);
    step(1);

    // not ready for two periods -> one overrun, one queued tick
    sif.i_ready = 1'b0;
    frames(60);
    check("overrun_missed", int'(sif.o_missed), 1);
    check("overrun_cnt", tick_cnt, 2);
    sif.i_ready = 1'b1;
    step(1);
    check("ready_tick", int'(sif.o_tick), 1);
    step(2);
    check("ready_single", tick_cnt, 3);

    // level 1 -> period 28
    eats(4);
    check("level1", int'(sif.o_level), 1);
    c0 = tick_cnt;
    frames(27); step(1);
    check("p28_no_tick", tick_cnt, c0);
    frames(1);
    check("p28_tick", int'(sif.o_tick), 1);
    step(1);

    // level 12 -> period 6
    eats(44);
    check("level12", int'(sif.o_level), 12);
    c0 = tick_cnt;
    frames(5); step(1);
    check("p6_no_tick", tick_cnt, c0);
    frames(1);
    check("p6_tick", int'(sif.o_tick), 1);
    step(1);
    eats(4);
    check("level_sat", int'(sif.o_level), 12);

    // reset mid-game, pause edge in IDLE ignored
    do_reset();
    check("rst2_level",  int'(sif.o_level),  0);
    check("rst2_missed", int'(sif.o_missed), 0);
    check("rst2_state",  int'(sif.o_state),  0);
    sif.i_pause = 1'b1; step(1);
    check("idle_pause", int'(sif.o_state), 0);
    sif.i_pause = 1'b0; step(1);

    // pause at frame_cnt=10, resume, tick after 20 more frames
    start();
    frames(10);
    sif.i_pause = 1'b1; step(1);
    check("pause_state", int'(sif.o_state), 2);
    c0 = tick_cnt;
    frames(30); step(1);
    check("pause_no_tick", tick_cnt, c0);
    check("pause_hold", int'(sif.o_state), 2);
    sif.i_pause = 1'b0; step(1);
    sif.i_pause = 1'b1; step(1);
    check("resume_state", int'(sif.o_state), 1);
    sif.i_pause = 1'b0;
    frames(19); step(1);
    check("resume_no_tick", tick_cnt, c0);
    frames(1);
    check("resume_tick", int'(sif.o_tick), 1);
    step(1);

    // failure beats success; OVER is terminal
    sif.i_failure = 1'b1; sif.i_success = 1'b1; step(1);
    sif.i_failure = 1'b0; sif.i_success = 1'b0;
    check("over_state", int'(sif.o_state), 3);
    sif.i_start = 1'b1; sif.i_pause = 1'b1; step(2);
    sif.i_pause = 1'b0; step(1);
    sif.i_pause = 1'b1; step(1);
    sif.i_start = 1'b0; sif.i_pause = 1'b0;
    check("over_terminal", int'(sif.o_state), 3);
    c0 = tick_cnt;
    frames(40); eats(4); step(1);
    check("over_no_tick", tick_cnt, c0);
    check("over_no_level", int'(sif.o_level), 0);

    // success -> WIN
    do_reset();
    start();
    sif.i_success = 1'b1; step(1); sif.i_success = 1'b0;
    check("win_state", int'(sif.o_state), 4);

    // boost at level 0
    do_reset();
    start();
    sif.i_boost = 1'b1;
    c0 = tick_cnt;
`ifdef SCHED_BOOST_EN
    frames(14);
`else
    frames(29);
`endif
    step(1);
    check("boost_no_tick", tick_cnt, c0);
    frames(1);
    check("boost_tick", int'(sif.o_tick), 1);
    sif.i_boost = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
